// File: rtl/mem_pkg.sv
// mem_pkg: shared line-memory constants, FSM state type and line-index extraction
//   LINE_W    : cache line width in bits
//   LINE_OFS  : byte-offset bits inside a line, log2(LINE_W/8)
//   state_e   : request FSM states
//   line_idx  : pulls the line index out of a byte address; higher bits alias
package mem_pkg;

    localparam int LINE_W   = 256;
    localparam int LINE_OFS = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

    function automatic logic [31:0] line_idx(input logic [63:0] addr, input int idx_w);
        logic [63:0] s;
        s = addr >> LINE_OFS;
        return s[31:0] & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/line_data_memory_if.sv
// line_data_memory_if: cache-to-memory line request/response bundle
//   enable_i : request valid, held until ack_o
//   write_i  : 1 = line write, 0 = line read
//   addr_i   : byte address of the line
//   data_i   : write line data
//   ack_o    : one-cycle completion pulse
//   data_o   : registered read line data
interface line_data_memory_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);

    logic              enable_i;
    logic              write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o
    );

endinterface

// File: rtl/line_ram.sv
// line_ram: DEPTH x W synchronous single-port array with registered read data
//   clk_i/rst_i : clock, async active-high reset (clears read register only)
//   en_i/we_i   : access strobe and write select
//   addr_i      : line index
//   wdata_i     : write line
//   rdata_o     : read line, holds its value between reads
module line_ram #(
    parameter int W     = 256,
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q, rdata_d;

    always_comb rdata_d = (en_i && !we_i) ? mem[addr_i] : rdata_q;

    // The array itself is never reset so that contents can be preloaded.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) mem[addr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_data_memory.sv
// line_data_memory: off-chip line memory answering each request after a fixed latency
//   clk_i : clock
//   rst_i : async active-high reset, aborts any request in flight
//   bus   : slave side of line_data_memory_if (enable/write/addr/data in, ack/data out)
module line_data_memory #(
    parameter int LINE_W  = mem_pkg::LINE_W,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    line_data_memory_if.slave   bus
);

    import mem_pkg::*;

    localparam int IDX   = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              write_q, write_d;
    logic [IDX-1:0]    idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              fire;

    // The access happens on the edge that leaves WAIT, so read data and ack
    // both become visible in the ACK cycle.
    always_comb begin
        fire    = (state_q == WAIT) && (cnt_q == '0);
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ack_d   = fire;
        case (state_q)
            IDLE: begin
                if (bus.enable_i) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    write_d = bus.write_i;
                    idx_d   = IDX'(line_idx(64'(bus.addr_i), IDX));
                    wdata_d = bus.data_i;
                end
            end
            WAIT: begin
                state_d = fire ? ACK : WAIT;
                cnt_d   = fire ? '0 : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    line_ram #(
        .W     (LINE_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (fire),
        .we_i    (write_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (bus.data_o)
    );

    assign bus.ack_o = ack_q;

endmodule
